// File: rtl/result_demux_if.sv
// Bus bundle for result_demux: the producer stream (valid/ready/data/sel)
// and the two consumer streams (A = register-file writeback, B = store path)
// with their occupancy counts.
//   slave  : the demux side (drives in_ready and the A/B outputs)
//   master : the environment side (drives the producer and consumer-ready signals)
interface result_demux_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // producer stream
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;

    // port A: register-file writeback
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic [CW-1:0]    a_count;

    // port B: data-memory store path
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;
    logic [CW-1:0]    b_count;

    modport slave (
        input  in_valid, in_data, in_sel, a_ready, b_ready,
        output in_ready, a_valid, a_data, a_count, b_valid, b_data, b_count
    );

    modport master (
        output in_valid, in_data, in_sel, a_ready, b_ready,
        input  in_ready, a_valid, a_data, a_count, b_valid, b_data, b_count
    );
endinterface

// File: rtl/result_demux.sv
// Buffered 1-to-2 demultiplexer at the distribution end of the operand-select
// path. One producer stream is steered by in_sel into one of two independent
// FIFOs, so a stalled consumer never blocks traffic to the other port.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high reset
//   bus   : result_demux_if.slave (producer stream, port A, port B, counts)
// Parameters:
//   WIDTH : data width (default 64)
//   DEPTH : entries per output FIFO, DEPTH >= 2, any value
module result_demux #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    result_demux_if.slave bus
);
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NPORT = 2;

    // index 0 = port A, index 1 = port B
    logic [WIDTH-1:0] mem_q   [NPORT][DEPTH];
    logic [PW-1:0]    wptr_q  [NPORT];
    logic [PW-1:0]    wptr_d  [NPORT];
    logic [PW-1:0]    rptr_q  [NPORT];
    logic [PW-1:0]    rptr_d  [NPORT];
    logic [CW-1:0]    count_q [NPORT];
    logic [CW-1:0]    count_d [NPORT];

    logic             port_ready [NPORT];
    logic             push       [NPORT];
    logic             pop        [NPORT];
    logic             accept;

    // Pointer advance with wrap from DEPTH-1 to 0 (DEPTH need not be 2^n).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign port_ready[0] = bus.a_ready;
    assign port_ready[1] = bus.b_ready;

    // Ready looks only at registered counts of the selected FIFO, so a full
    // FIFO refuses a push even when its consumer pops in the same cycle; this
    // keeps a_ready/b_ready out of the in_ready path.
    assign bus.in_ready = (bus.in_sel ? count_q[1] : count_q[0]) != CW'(DEPTH);
    assign accept       = bus.in_valid & bus.in_ready;

    // Per-port push/pop qualification and next-state pointers/counts.
    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            push[p]    = accept & (bus.in_sel == 1'(p));
            pop[p]     = (count_q[p] != '0) & port_ready[p];
            wptr_d[p]  = wptr_q[p];
            rptr_d[p]  = rptr_q[p];
            count_d[p] = count_q[p];
            if (push[p]) begin
                wptr_d[p] = ptr_inc(wptr_q[p]);
            end
            if (pop[p]) begin
                rptr_d[p] = ptr_inc(rptr_q[p]);
            end
            case ({push[p], pop[p]})
                2'b10:   count_d[p] = count_q[p] + CW'(1);
                2'b01:   count_d[p] = count_q[p] - CW'(1);
                default: count_d[p] = count_q[p];
            endcase
        end
    end

    // State registers; reset clears storage too so the data outputs read 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NPORT; p++) begin
                wptr_q[p]  <= '0;
                rptr_q[p]  <= '0;
                count_q[p] <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[p][e] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                wptr_q[p]  <= wptr_d[p];
                rptr_q[p]  <= rptr_d[p];
                count_q[p] <= count_d[p];
                if (push[p]) begin
                    mem_q[p][wptr_q[p]] <= bus.in_data;
                end
            end
        end
    end

    // Heads are read straight from storage at the read pointer.
    assign bus.a_valid = (count_q[0] != '0);
    assign bus.a_data  = mem_q[0][rptr_q[0]];
    assign bus.a_count = count_q[0];
    assign bus.b_valid = (count_q[1] != '0);
    assign bus.b_data  = mem_q[1][rptr_q[1]];
    assign bus.b_count = count_q[1];

    // Occupancy never exceeds the FIFO depth.
    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count_q[0] <= CW'(DEPTH));
    b_count_bound: assert property (@(posedge clk) disable iff (reset)
        count_q[1] <= CW'(DEPTH));
endmodule

// File: tb/tb_result_demux.sv
// Directed, self-checking bench for result_demux (WIDTH=64, DEPTH=2).
// Inputs change 1ns after each rising edge; outputs are checked mid-cycle.
module tb_result_demux;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned DEPTH = 2;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    result_demux_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    result_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #3;
    endtask

    task automatic drive(input logic v, input logic s, input logic [63:0] d);
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sel   = 1'b0;
        bus.in_data  = '0;
        bus.a_ready  = 1'b0;
        bus.b_ready  = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        settle();

        // Reset state
        check("rst_a_count", 64'(bus.a_count), 64'd0);
        check("rst_b_count", 64'(bus.b_count), 64'd0);
        check("rst_a_valid", 64'(bus.a_valid), 64'd0);
        check("rst_b_valid", 64'(bus.b_valid), 64'd0);
        check("rst_a_data",  bus.a_data, 64'd0);
        check("rst_b_data",  bus.b_data, 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // 1: single transfer to A, visible next cycle
        step();
        drive(1'b1, 1'b0, 64'h0000_0000_DEAD_BEEF);
        settle();
        check("t1_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        drive(1'b0, 1'b0, 64'd0);
        settle();
        check("t1_a_valid", 64'(bus.a_valid), 64'd1);
        check("t1_a_data",  bus.a_data, 64'hDEAD_BEEF);
        check("t1_a_count", 64'(bus.a_count), 64'd1);
        check("t1_b_valid", 64'(bus.b_valid), 64'd0);

        // 2: fill B, backpressure on word 3, then drain in order
        step();
        drive(1'b1, 1'b1, 64'd1);
        settle();
        check("t2_rdy_w1", 64'(bus.in_ready), 64'd1);
        step();
        drive(1'b1, 1'b1, 64'd2);
        settle();
        check("t2_rdy_w2", 64'(bus.in_ready), 64'd1);
        step();
        drive(1'b1, 1'b1, 64'd3);
        settle();
        check("t2_rdy_w3", 64'(bus.in_ready), 64'd0);
        check("t2_b_count_full", 64'(bus.b_count), 64'd2);
        step();
        settle();
        check("t2_w3_held", 64'(bus.b_count), 64'd2);
        bus.b_ready = 1'b1;
        settle();
        check("t2_rdy_full_pop", 64'(bus.in_ready), 64'd0);
        check("t2_out1", bus.b_data, 64'd1);
        step();
        settle();
        check("t2_rdy_after_pop", 64'(bus.in_ready), 64'd1);
        check("t2_out2", bus.b_data, 64'd2);
        step();
        drive(1'b0, 1'b0, 64'd0);
        settle();
        check("t2_out3", bus.b_data, 64'd3);
        check("t2_b_count1", 64'(bus.b_count), 64'd1);
        step();
        bus.b_ready = 1'b0;
        settle();
        check("t2_b_empty", 64'(bus.b_valid), 64'd0);

        // 3: A full, B still accepts
        drive(1'b1, 1'b0, 64'h11);
        step();
        drive(1'b1, 1'b1, 64'hAAAA);
        settle();
        check("t3_a_full", 64'(bus.a_count), 64'd2);
        check("t3_rdy_b", 64'(bus.in_ready), 64'd1);
        step();
        drive(1'b0, 1'b0, 64'd0);
        settle();
        check("t3_b_valid", 64'(bus.b_valid), 64'd1);
        check("t3_b_data",  bus.b_data, 64'hAAAA);
        check("t3_a_count", 64'(bus.a_count), 64'd2);
        bus.b_ready = 1'b1;
        step();
        bus.b_ready = 1'b0;

        // 5: A full with concurrent pop: pop happens, push retried next cycle
        bus.a_ready = 1'b1;
        drive(1'b1, 1'b0, 64'h55);
        settle();
        check("t5_rdy_full", 64'(bus.in_ready), 64'd0);
        check("t5_head0", bus.a_data, 64'hDEAD_BEEF);
        step();
        settle();
        check("t5_rdy_retry", 64'(bus.in_ready), 64'd1);
        check("t5_head1", bus.a_data, 64'h11);
        check("t5_count1", 64'(bus.a_count), 64'd1);
        step();
        drive(1'b0, 1'b0, 64'd0);
        settle();
        check("t5_head2", bus.a_data, 64'h55);
        check("t5_count2", 64'(bus.a_count), 64'd1);
        step();
        settle();
        check("t5_empty", 64'(bus.a_valid), 64'd0);

        // 4: streaming with a_ready held high, pointers wrap repeatedly
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 64'(i));
            settle();
            if (i == 0) begin
                check("t4_no_underflow", 64'(bus.a_count), 64'd0);
            end else begin
                check($sformatf("t4_data%0d", i - 1), bus.a_data, 64'(i - 1));
                check($sformatf("t4_count%0d", i), 64'(bus.a_count), 64'd1);
            end
            step();
        end
        drive(1'b0, 1'b0, 64'd0);
        settle();
        check("t4_data9", bus.a_data, 64'd9);
        check("t4_count_last", 64'(bus.a_count), 64'd1);
        step();
        settle();
        check("t4_drained", 64'(bus.a_count), 64'd0);

        // 6: reset mid-operation discards everything
        bus.a_ready = 1'b0;
        drive(1'b1, 1'b0, 64'hA1);
        step();
        drive(1'b1, 1'b0, 64'hA2);
        step();
        drive(1'b1, 1'b1, 64'hB1);
        step();
        drive(1'b0, 1'b0, 64'd0);
        settle();
        check("t6_pre_a", 64'(bus.a_count), 64'd2);
        check("t6_pre_b", 64'(bus.b_count), 64'd1);
        check("t6_pre_bdata", bus.b_data, 64'hB1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        settle();
        check("t6_a_count", 64'(bus.a_count), 64'd0);
        check("t6_b_count", 64'(bus.b_count), 64'd0);
        check("t6_a_valid", 64'(bus.a_valid), 64'd0);
        check("t6_b_valid", 64'(bus.b_valid), 64'd0);
        check("t6_a_data",  bus.a_data, 64'd0);
        check("t6_b_data",  bus.b_data, 64'd0);
        check("t6_in_ready", 64'(bus.in_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
